// File: rtl/despacho_pkg.sv
// -----------------------------------------------------------------------------
// despacho_pkg
// Shared constants for the Tomasulo dispatch stage: instruction field layout,
// opcode encodings, the "register free" tag value and the stall FSM states.
// Imported by the dispatch interface, the station picker and the top level.
// -----------------------------------------------------------------------------
package despacho_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned REG_W = 3;

  // Instruction word: [15:13] opcode, [12:10] Ri, [9:7] Rj, [6:4] Rk, [3:0] unused
  localparam int unsigned OP_LSB = 13;
  localparam int unsigned RI_LSB = 10;
  localparam int unsigned RJ_LSB = 7;
  localparam int unsigned RK_LSB = 4;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_MUL = 3'b011;
  localparam logic [OP_W-1:0] OP_DIV = 3'b100;

  // Qi value meaning "no producer pending"; station k owns tag k+1
  localparam int unsigned TAG_FREE = 0;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/unidade_despacho_param_if.sv
// -----------------------------------------------------------------------------
// unidade_despacho_param_if
// Bundle between the dispatch stage and its environment.
//   Queue side     : Instr_valid, Instrucao_Despachada -> ; <- Pop
//   Register table : Rs_Qi, Rs_Qi_data -> ; <- R_enable/target/res_station
//   Stations       : Busy -> ; <- Enable_VQ, Ufop, Vj, Vk, Qj, Qk
//   CDB            : Cdb_valid, Cdb_tag, Cdb_data ->
//   Status         : <- Stalled, Stall_cycles
// modport master = dispatch unit, modport slave = environment.
// -----------------------------------------------------------------------------
interface unidade_despacho_param_if
  import despacho_pkg::*;
#(
  parameter int unsigned N_RS   = 2,
  parameter int unsigned N_REG  = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3
);
  logic                    Instr_valid;
  logic [15:0]             Instrucao_Despachada;
  logic [N_REG*TAG_W-1:0]  Rs_Qi;
  logic [N_REG*DATA_W-1:0] Rs_Qi_data;
  logic [N_RS-1:0]         Busy;
  logic                    Cdb_valid;
  logic [TAG_W-1:0]        Cdb_tag;
  logic [DATA_W-1:0]       Cdb_data;

  logic                    Pop;
  logic [N_RS-1:0]         Enable_VQ;
  logic [OP_W-1:0]         Ufop;
  logic [DATA_W-1:0]       Vj;
  logic [DATA_W-1:0]       Vk;
  logic [TAG_W-1:0]        Qj;
  logic [TAG_W-1:0]        Qk;
  logic                    R_enable_despacho;
  logic [REG_W-1:0]        R_target_despacho;
  logic [TAG_W-1:0]        R_res_station_despacho;
  logic                    Stalled;
  logic [15:0]             Stall_cycles;

  modport master (
    input  Instr_valid, Instrucao_Despachada, Rs_Qi, Rs_Qi_data, Busy,
           Cdb_valid, Cdb_tag, Cdb_data,
    output Pop, Enable_VQ, Ufop, Vj, Vk, Qj, Qk, R_enable_despacho,
           R_target_despacho, R_res_station_despacho, Stalled, Stall_cycles
  );

  modport slave (
    output Instr_valid, Instrucao_Despachada, Rs_Qi, Rs_Qi_data, Busy,
           Cdb_valid, Cdb_tag, Cdb_data,
    input  Pop, Enable_VQ, Ufop, Vj, Vk, Qj, Qk, R_enable_despacho,
           R_target_despacho, R_res_station_despacho, Stalled, Stall_cycles
  );

endinterface

// File: rtl/despacho_alloc.sv
// -----------------------------------------------------------------------------
// despacho_alloc
// Combinational free-station picker. A station is available when neither busy
// nor masked. ALLOC_MODE 0: lowest available index. ALLOC_MODE 1: round-robin,
// searching from ptr_i+1 upwards with wrap-around.
//   busy_i, mask_i : per-station flags
//   ptr_i          : index of the last granted station
//   grant_o        : one-hot grant, found_o: any grant, idx_o: granted index
// -----------------------------------------------------------------------------
module despacho_alloc #(
  parameter int unsigned N_RS       = 2,
  parameter int unsigned ALLOC_MODE = 0,
  parameter int unsigned PTR_W      = (N_RS > 1) ? $clog2(N_RS) : 1
) (
  input  logic [N_RS-1:0]  busy_i,
  input  logic [N_RS-1:0]  mask_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_RS-1:0]  grant_o,
  output logic             found_o,
  output logic [PTR_W-1:0] idx_o
);
  logic [N_RS-1:0] avail;
  logic [31:0]     cand;

  assign avail = ~busy_i & ~mask_i;

  // Walk candidates in priority order; the first available one wins.
  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned off = 0; off < N_RS; off++) begin
      cand = (ALLOC_MODE == 1) ? (32'(ptr_i) + off + 32'd1) % N_RS : off;
      for (int unsigned k = 0; k < N_RS; k++) begin
        if (!found_o && k == cand && avail[k]) begin
          found_o    = 1'b1;
          grant_o[k] = 1'b1;
          idx_o      = PTR_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/unidade_despacho_param.sv
// -----------------------------------------------------------------------------
// unidade_despacho_param
// Tomasulo issue stage: takes the queue head, resolves Vj/Vk/Qj/Qk from the
// register-status table (with rename bypass and CDB forwarding), allocates a
// reservation station and posts the rename. Stalls while no station is free.
//   Clock, Reset_n : clock, asynchronous active-low reset
//   bus            : unidade_despacho_param_if.master (see interface header)
// All outputs are registered (1-cycle latency).
// -----------------------------------------------------------------------------
module unidade_despacho_param
  import despacho_pkg::*;
#(
  parameter int unsigned       N_RS       = 2,
  parameter int unsigned       N_REG      = 8,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       TAG_W      = 3,
  parameter int unsigned       ALLOC_MODE = 0,
  parameter logic [DATA_W-1:0] SEM_VALOR  = DATA_W'(16'hFFF0)
) (
  input logic Clock,
  input logic Reset_n,
  unidade_despacho_param_if.master bus
);
  localparam int unsigned PTR_W = (N_RS > 1) ? $clog2(N_RS) : 1;

  state_t            state_q;
  logic              pop_q, ren_q, stalled_q;
  logic [N_RS-1:0]   en_q;
  logic [OP_W-1:0]   ufop_q;
  logic [DATA_W-1:0] vj_q, vk_q;
  logic [TAG_W-1:0]  qj_q, qk_q, rtag_q;
  logic [REG_W-1:0]  rtgt_q;
  logic [15:0]       stall_cnt_q;
  logic [PTR_W-1:0]  rr_ptr_q;

  logic [OP_W-1:0]   op;
  logic [REG_W-1:0]  ri, rj, rk;
  logic              unused_low_bits;

  assign op = bus.Instrucao_Despachada[OP_LSB +: OP_W];
  assign ri = bus.Instrucao_Despachada[RI_LSB +: REG_W];
  assign rj = bus.Instrucao_Despachada[RJ_LSB +: REG_W];
  assign rk = bus.Instrucao_Despachada[RK_LSB +: REG_W];
  assign unused_low_bits = ^bus.Instrucao_Despachada[RK_LSB-1:0];

  logic [TAG_W-1:0]  qi_a [N_REG];
  logic [DATA_W-1:0] dt_a [N_REG];

  for (genvar g = 0; g < N_REG; g++) begin : g_unpack
    assign qi_a[g] = bus.Rs_Qi[g*TAG_W +: TAG_W];
    assign dt_a[g] = bus.Rs_Qi_data[g*DATA_W +: DATA_W];
  end

  // Returns {V, Q} for an operand whose producer tag is t.
  function automatic logic [DATA_W+TAG_W-1:0] resolve(
    input logic [TAG_W-1:0]  t,
    input logic [DATA_W-1:0] reg_data,
    input logic              cdb_v,
    input logic [TAG_W-1:0]  cdb_t,
    input logic [DATA_W-1:0] cdb_d
  );
    if (t == TAG_W'(TAG_FREE)) return {reg_data, {TAG_W{1'b0}}};
    if (cdb_v && cdb_t == t)   return {cdb_d, {TAG_W{1'b0}}};
    return {SEM_VALOR, t};
  endfunction

  // The rename registered last cycle is not yet in Rs_Qi; the registered
  // rename outputs double as the bypass entry.
  logic [TAG_W-1:0]        tag_j, tag_k;
  logic [DATA_W+TAG_W-1:0] opnd_j_d, opnd_k_d;

  assign tag_j = (ren_q && rtgt_q == rj) ? rtag_q : qi_a[rj];
  assign tag_k = (ren_q && rtgt_q == rk) ? rtag_q : qi_a[rk];
  assign opnd_j_d = resolve(tag_j, dt_a[rj], bus.Cdb_valid, bus.Cdb_tag, bus.Cdb_data);
  assign opnd_k_d = resolve(tag_k, dt_a[rk], bus.Cdb_valid, bus.Cdb_tag, bus.Cdb_data);

  logic [N_RS-1:0]  grant;
  logic             found;
  logic [PTR_W-1:0] grant_idx;

  // Last cycle's grant (en_q) masks its station until its Busy shows up.
  despacho_alloc #(
    .N_RS      (N_RS),
    .ALLOC_MODE(ALLOC_MODE),
    .PTR_W     (PTR_W)
  ) u_alloc (
    .busy_i (bus.Busy),
    .mask_i (en_q),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .found_o(found),
    .idx_o  (grant_idx)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_ISSUE;
      pop_q       <= 1'b0;
      en_q        <= '0;
      ufop_q      <= '0;
      vj_q        <= SEM_VALOR;
      vk_q        <= SEM_VALOR;
      qj_q        <= '0;
      qk_q        <= '0;
      ren_q       <= 1'b0;
      rtgt_q      <= '0;
      rtag_q      <= '0;
      stalled_q   <= 1'b0;
      stall_cnt_q <= '0;
      rr_ptr_q    <= PTR_W'(N_RS - 1);
    end else begin
      pop_q <= 1'b0;
      en_q  <= '0;
      ren_q <= 1'b0;
      if (state_q == ST_STALL && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      // ISSUE and STALL share the issue path; they differ only in counting.
      if (bus.Instr_valid && op != OP_NOP && !found) begin
        state_q   <= ST_STALL;
        stalled_q <= 1'b1;
      end else begin
        state_q   <= ST_ISSUE;
        stalled_q <= 1'b0;
        if (bus.Instr_valid && op == OP_NOP) begin
          pop_q <= 1'b1;
        end else if (bus.Instr_valid) begin
          pop_q    <= 1'b1;
          en_q     <= grant;
          ufop_q   <= op;
          vj_q     <= opnd_j_d[TAG_W +: DATA_W];
          qj_q     <= opnd_j_d[TAG_W-1:0];
          vk_q     <= opnd_k_d[TAG_W +: DATA_W];
          qk_q     <= opnd_k_d[TAG_W-1:0];
          ren_q    <= 1'b1;
          rtgt_q   <= ri;
          rtag_q   <= TAG_W'(grant_idx) + TAG_W'(1);
          rr_ptr_q <= grant_idx;
        end
      end
    end
  end

  assign bus.Pop                    = pop_q;
  assign bus.Enable_VQ              = en_q;
  assign bus.Ufop                   = ufop_q;
  assign bus.Vj                     = vj_q;
  assign bus.Vk                     = vk_q;
  assign bus.Qj                     = qj_q;
  assign bus.Qk                     = qk_q;
  assign bus.R_enable_despacho      = ren_q;
  assign bus.R_target_despacho      = rtgt_q;
  assign bus.R_res_station_despacho = rtag_q;
  assign bus.Stalled                = stalled_q;
  assign bus.Stall_cycles           = stall_cnt_q;

endmodule

// File: doc/unidade_despacho_param.md
Name: unidade_despacho_param

Overview:
Parametrised successor of the Tomasulo dispatch (issue) stage. It takes one instruction per cycle from the instruction queue and reads the register-status table (Qi tag plus data per register). It allocates one of N_RS reservation stations, using either fixed-priority or round-robin selection. It sends the resolved Vj/Vk/Qj/Qk operands to that station and posts the rename to the register table. Unlike the previous generation, it adds:
- a valid/pop handshake;
- CDB forwarding during dispatch;
- a back-to-back rename bypass and busy masking;
- a stall FSM with a stall counter.

Parameters:
N_RS, 2, number of reservation stations (1..7).
N_REG, 8, architectural registers; register index width is 3.
DATA_W, 16, operand width.
TAG_W, 3, tag width. Tag 0 = register free; station k uses tag k+1.
ALLOC_MODE, 0, 0 = lowest free index wins, 1 = round-robin starting after the last grant.
SEM_VALOR, 16'hFFF0, Vj/Vk value driven when the operand is pending.

Ports:
Clock  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Instr_valid  in  1  queue head holds a valid instruction
Instrucao_Despachada  in  16  [15:13] opcode, [12:10] Ri, [9:7] Rj, [6:4] Rk
Rs_Qi  in  N_REG*TAG_W  flattened per-register tag
Rs_Qi_data  in  N_REG*DATA_W  flattened per-register data
Busy  in  N_RS  station busy flags
Cdb_valid  in  1  common data bus broadcast valid
Cdb_tag  in  TAG_W  producing station tag
Cdb_data  in  DATA_W  broadcast result
Pop  out  1  one-cycle pulse: queue head consumed
Enable_VQ  out  N_RS  one-hot one-cycle load strobe to a station
Ufop  out  3  opcode for the enabled station
Vj, Vk  out  DATA_W  operand values
Qj, Qk  out  TAG_W  pending operand tags
R_enable_despacho  out  1  one-cycle rename write strobe
R_target_despacho  out  3  rename destination register
R_res_station_despacho  out  TAG_W  tag written into Qi[Ri]
Stalled  out  1  FSM in STALL
Stall_cycles  out  16  saturating count of stall cycles

Behaviour:
Reset (Reset_n low, asynchronous):
- Vj = Vk = SEM_VALOR; Qj = Qk = 0; Ufop = 0.
- Enable_VQ = 0; Pop = 0; R_enable_despacho = 0; R_target_despacho = 0; R_res_station_despacho = 0.
- Stalled = 0; Stall_cycles = 0; round-robin pointer = N_RS-1, so the first grant goes to station 0.
- Bypass register cleared. Reset asserted mid-stall aborts the stall; no partial issue.

Pulsed outputs:
- Pop, Enable_VQ and R_enable_despacho default to 0 every cycle.
- All outputs are registered, so a sampled instruction appears on the outputs at the next edge (1-cycle latency).

FSM states: ISSUE and STALL.
- ISSUE, Instr_valid=0: no action.
- ISSUE, valid with opcode 000 (NOP): Pop=1 only.
- ISSUE, valid non-NOP: select the station k from Avail = ~Busy & ~Mask, per ALLOC_MODE.
  - Mask = the station granted in the previous cycle, because its Busy is not yet visible.
  - Granting station k drives: Enable_VQ[k]=1, Ufop=opcode, Pop=1, R_enable_despacho=1, R_target_despacho=Ri, R_res_station_despacho=k+1.
  - The round-robin pointer is updated to k.
- ISSUE, Avail==0: go to STALL with Stalled=1. Pop stays 0 and the instruction is held.
- STALL: Stall_cycles increments each cycle and saturates at 16'hFFFF. When Avail!=0, issue the same way as ISSUE, return to ISSUE, and set Stalled=0. Stall_cycles is never cleared except by reset.

Operand resolution, for each source s in {Rj, Rk}, in priority order:
1. Bypass: the previous cycle issued a rename and its Ri==s. Use tag = previous station tag, because the register table is not yet updated. The CDB check in step 2 still applies to this tag.
2. Tag t = Rs_Qi[s] (or the bypass tag). If t==0: V = Rs_Qi_data[s], Q = 0.
3. If Cdb_valid and Cdb_tag==t: V = Cdb_data, Q = 0.
4. Otherwise: V = SEM_VALOR, Q = t.

Other rules:
- Sources are resolved before this instruction's own rename. For example, ADD R1,R1,R2 reads the old R1 status.
- The CDB matching the tag being renamed in the same cycle has no effect on the rename.

Decomposition:
- Package despacho_pkg: opcode localparams (OP_NOP=3'b000 and others), TAG_FREE=0, instruction field slice constants, FSM state encoding.
- Sub-module despacho_alloc: a combinational free-station picker for Busy/Mask/pointer/mode that returns a one-hot grant and a found flag. It is reused by the future load/store dispatch.

Test Plan:
- Reset then valid ADD R3,R1,R2 with all Rs_Qi=0, R1=5, R2=7 → next edge: Enable_VQ=01, Vj=5, Vk=7, Qj=Qk=0, R_res_station_despacho=1, Pop=1.
- Two back-to-back ADDs, the second reading R3 written by the first; Rs_Qi stale → second: Qj=1 (bypass), Enable_VQ=10 (masked station 0), Vj=FFF0.
- Rs_Qi[R1]=2 with Cdb_valid, Cdb_tag=2, Cdb_data=0x1234 in the same cycle → Vj=0x1234, Qj=0.
- Busy=11 for 4 cycles, then Busy=01 → Stalled=1, Pop=0 for 4 cycles, Stall_cycles=4; then Enable_VQ=10, Pop=1, Stalled=0.
- ALLOC_MODE=1, Busy=00, three independent instructions spaced 2 cycles apart → grants to stations 0, 1, 0.
- NOP at the head → Pop=1, Enable_VQ=0, R_enable_despacho=0. Reset_n pulled low during STALL → all outputs return to reset values asynchronously.
